// File: rtl/mem_stage_module.sv
// Memory pipeline stage: word-addressed data memory with programmable wait states,
// upstream freeze via ready, forwarding taps and the MEM/WB pipeline register.
module mem_stage_module #(
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic        wb_en_hazard,
    output logic [3:0]  dest_hazard,
    output logic [31:0] MEM_wb_value,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_buf;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic        req;
    logic        access;
    logic        do_write;

    assign offset   = alu_res_in - BASE;
    assign in_range = offset < SPAN;
    assign idx      = offset[AW+1:2];
    assign rd_word  = in_range ? mem[idx] : 32'd0;
    assign req      = mem_r_en_in | mem_w_en_in;

    assign wb_en_hazard = wb_en_in;
    assign dest_hazard  = dest_in;
    assign MEM_wb_value = alu_res_in;

    // The array is touched in the last stalled cycle, so ready stays low for exactly LATENCY cycles.
    assign access   = ((state == IDLE) && req && (LATENCY <= 1)) ||
                      ((state == BUSY) && (cnt == 4'd0));
    assign do_write = access && mem_w_en_in && in_range && !rst;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = !req || (LATENCY == 0);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[idx] <= val_Rm_in;
    end

    always_ff @(posedge clk) begin
        if (access)
            rd_buf <= rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && (LATENCY != 0)) begin
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= DONE;
                end
                // Upstream is still frozen here, so the request is still visible; never re-issue it.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
            dest_out     <= 4'd0;
        end else if (ready) begin
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            alu_res_out  <= alu_res_in;
            mem_data_out <= mem_r_en_in ? ((state == DONE) ? rd_buf : rd_word) : 32'd0;
            dest_out     <= dest_in;
        end else begin
            // Stall bubble: suppress write-back while data fields hold.
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            dest_out     <= 4'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_module.sv
// Scoreboard bench for mem_stage_module: one instance with two wait states, one with none.
module tb_mem_stage_module;

    typedef struct packed {
        logic        wb;
        logic        r;
        logic [31:0] alu;
        logic [31:0] data;
        logic [3:0]  dest;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        w_i [2];
    logic        r_i [2];
    logic        wb_i [2];
    logic [31:0] alu_i [2];
    logic [31:0] rm_i [2];
    logic [3:0]  dest_i [2];

    logic        ready_o [2];
    logic        wbh_o [2];
    logic [3:0]  desth_o [2];
    logic [31:0] fwd_o [2];
    logic        wb_o [2];
    logic        mr_o [2];
    logic [31:0] alu_o [2];
    logic [31:0] data_o [2];
    logic [3:0]  dest_o [2];

    mem_stage_module #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_i[0]), .mem_r_en_in(r_i[0]), .mem_w_en_in(w_i[0]),
        .alu_res_in(alu_i[0]), .val_Rm_in(rm_i[0]), .dest_in(dest_i[0]),
        .ready(ready_o[0]), .wb_en_hazard(wbh_o[0]), .dest_hazard(desth_o[0]),
        .MEM_wb_value(fwd_o[0]), .wb_en_out(wb_o[0]), .mem_r_en_out(mr_o[0]),
        .alu_res_out(alu_o[0]), .mem_data_out(data_o[0]), .dest_out(dest_o[0])
    );

    mem_stage_module #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_i[1]), .mem_r_en_in(r_i[1]), .mem_w_en_in(w_i[1]),
        .alu_res_in(alu_i[1]), .val_Rm_in(rm_i[1]), .dest_in(dest_i[1]),
        .ready(ready_o[1]), .wb_en_hazard(wbh_o[1]), .dest_hazard(desth_o[1]),
        .MEM_wb_value(fwd_o[1]), .wb_en_out(wb_o[1]), .mem_r_en_out(mr_o[1]),
        .alu_res_out(alu_o[1]), .mem_data_out(data_o[1]), .dest_out(dest_o[1])
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          sel    = 0;
    logic        pend   = 1'b0;
    exp_t        sb [$];
    logic [31:0] model [2][64];

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nop(input int i);
        w_i[i] = 1'b0; r_i[i] = 1'b0; wb_i[i] = 1'b0;
        alu_i[i] = 32'd0; rm_i[i] = 32'd0; dest_i[i] = 4'd0;
    endtask

    // Drive one instruction on the selected instance, hold it until ready, then release.
    task automatic issue(input logic w, input logic r, input logic wb, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] dst, input int exp_stall);
        exp_t        e;
        logic [31:0] off;
        int          stalls;
        off    = a - 32'd1024;
        e.wb   = wb;
        e.r    = r;
        e.alu  = a;
        e.dest = dst;
        e.data = (r && off < 32'd256) ? model[sel][off[7:2]] : 32'd0;
        if (w && off < 32'd256)
            model[sel][off[7:2]] = d;
        sb.push_back(e);
        w_i[sel] = w; r_i[sel] = r; wb_i[sel] = wb;
        alu_i[sel] = a; rm_i[sel] = d; dest_i[sel] = dst;
        pend = 1'b1;
        #1;
        check("tap", 72'({wbh_o[sel], desth_o[sel], fwd_o[sel]}), 72'({wb, dst, a}));
        stalls = 0;
        @(negedge clk);
        while (!ready_o[sel] && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        check("stall", 72'(stalls), 72'(exp_stall));
        @(posedge clk);
        #1;
        nop(sel);
        pend = 1'b0;
    endtask

    logic fire_q  = 1'b0;
    logic stall_q = 1'b0;
    int   fsel    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (fire_q) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mwb: output with empty scoreboard");
            end else begin
                e = sb.pop_front();
                check("mwb", 72'({wb_o[fsel], mr_o[fsel], alu_o[fsel], data_o[fsel], dest_o[fsel]}),
                      72'(e));
            end
        end
        if (stall_q)
            check("bubble", 72'({wb_o[fsel], mr_o[fsel], dest_o[fsel]}), 72'd0);
        fire_q  = ready_o[sel] && !rst && pend;
        stall_q = !ready_o[sel] && !rst && pend;
        fsel    = sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        nop(0);
        nop(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_mwb", 72'({wb_o[i], mr_o[i], alu_o[i], data_o[i], dest_o[i]}), 72'd0);
            check("rst_rdy", 72'(ready_o[i]), 72'd1);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        sel = 0;
        issue(1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd3, 0);
        issue(1'b1, 1'b0, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1028, 32'd0, 4'd5, 2);

        issue(1'b1, 1'b0, 1'b0, 32'd1024, 32'h600D0000, 4'd0, 2);
        issue(1'b1, 1'b0, 1'b0, 32'd1276, 32'hCAFEF00D, 4'd0, 2);
        issue(1'b1, 1'b0, 1'b0, 32'd1020, 32'h0000BAD1, 4'd0, 2);
        issue(1'b1, 1'b0, 1'b0, 32'd1280, 32'h0000BAD2, 4'd0, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1020, 32'd0, 4'd6, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1280, 32'd0, 4'd7, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1276, 32'd0, 4'd8, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd9, 2);

        issue(1'b1, 1'b0, 1'b0, 32'd1040, 32'h11, 4'd0, 2);
        issue(1'b1, 1'b1, 1'b1, 32'd1040, 32'hA5, 4'd10, 2);
        issue(1'b0, 1'b1, 1'b1, 32'd1040, 32'd0, 4'd11, 2);

        issue(1'b1, 1'b0, 1'b0, 32'd1036, 32'h0BAD, 4'd0, 2);
        w_i[0] = 1'b1; alu_i[0] = 32'd1036; rm_i[0] = 32'h1234; pend = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nop(0);
        pend = 1'b0;
        @(negedge clk);
        check("rstmid_mwb", 72'({wb_o[0], mr_o[0], alu_o[0], data_o[0], dest_o[0]}), 72'd0);
        check("rstmid_rdy", 72'(ready_o[0]), 72'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 1'b1, 1'b1, 32'd1036, 32'd0, 4'd12, 2);

        sel = 1;
        issue(1'b1, 1'b0, 1'b0, 32'd1024, 32'h1111AAAA, 4'd0, 0);
        issue(1'b1, 1'b0, 1'b0, 32'd1032, 32'h2222BBBB, 4'd0, 0);
        issue(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd1, 0);
        issue(1'b0, 1'b1, 1'b1, 32'd1032, 32'd0, 4'd2, 0);
        issue(1'b1, 1'b1, 1'b1, 32'd1032, 32'h33, 4'd4, 0);
        issue(1'b0, 1'b1, 1'b1, 32'd1032, 32'd0, 4'd13, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", 72'(sb.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
